uart_rx_oversample: RTL
=======================

// Module: uart_rx_oversample
// PURPOSE
//  8N1 UART receiver: consumer of the serial stream produced by UART_TX, on the peer board or in loopback.
//  Single-clock design: its own 16x oversample tick divider, 2-flop input synchronizer, 3-sample majority vote.
//  Delivers bytes through a held valid/ready register to the RX FIFO / bus logic.
//  Flags framing errors and overruns.
// PARAMETERS
//  TICK_DIV  27  clk cycles per oversample tick; baud = clk/(TICK_DIV*16). 27 gives ~115200 at 50 MHz. Legal range 2..255.
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  reset       in   1  asynchronous, active-low reset
//  iRX_DATA    in   1  serial line, asynchronous to clk, idle high
//  iRX_READY   in   1  consumer accepts oRX_BYTE this cycle when oRX_VALID=1
//  oRX_BYTE    out  8  received byte, LSB first on the line
//  oRX_VALID   out  1  oRX_BYTE holds an unconsumed byte
//  oFRAME_ERR  out  1  1-cycle pulse: stop bit sampled 0
//  oOVERRUN    out  1  1-cycle pulse: byte completed while register full and not popped
//  oBUSY       out  1  1 in any state other than IDLE
// BEHAVIOUR
//  Reset (async, reset=0):
//   - state=IDLE, all counters 0, sync flops=1.
//   - oRX_BYTE=0; oRX_VALID, oFRAME_ERR, oOVERRUN, oBUSY all 0.
//  Input path:
//   - rx_s = iRX_DATA through 2 flops, so 2-clk latency.
//   - All decisions use rx_s only.
//  Tick divider:
//   - tcnt counts 0..TICK_DIV-1; tick=1 for one clk when tcnt==TICK_DIV-1.
//   - tcnt and sample count scnt are forced to 0 on the IDLE->START transition, so bit timing is phase-locked to the start edge.
//   - scnt (0..15) increments on each tick.
//   - Samples are taken at scnt 7, 8 and 9; the bit value is the majority of the 3, evaluated on the tick where scnt==9.
//   - A bit period ends on the tick where scnt==15 (scnt wraps to 0).
//  State machine:
//   - IDLE: when rx_s=0, go to START.
//   - START, on majority eval:
//     - majority=1: false start, go to IDLE; no flags.
//     - majority=0: continue to end of bit, then DATA with bit index=0.
//   - DATA: on each majority eval, shift the bit into shreg[7] (LSB-first shift right).
//     - After the end-of-bit of index 7, go to STOP; otherwise index+1.
//   - STOP, on majority eval (scnt==9, no wait for end of bit):
//     - =1: deliver shreg, go to IDLE. A new start edge is accepted from the next clk.
//     - =0: pulse oFRAME_ERR, discard shreg, go to WAIT_IDLE.
//   - WAIT_IDLE: stay until rx_s=1 (break / stuck-low line), then go to IDLE. No further flags or bytes.
//  Deliver / handshake:
//   - pop = oRX_VALID & iRX_READY.
//   - On deliver, if !oRX_VALID or pop in the same cycle: oRX_BYTE<=shreg, oRX_VALID<=1.
//   - Otherwise: old byte kept, new byte dropped, oOVERRUN pulses 1 clk.
//   - pop without deliver: oRX_VALID<=0; oRX_BYTE keeps its value.
//   - oRX_BYTE is stable whenever oRX_VALID=1.
//   - Latency: oRX_VALID rises 1 clk after the stop-bit eval tick.
//  Reset mid-frame: everything returns to reset values immediately; the partial byte is lost. After release, reception restarts at the next falling edge of rx_s.
//  Widths: tcnt is 8 bits, scnt 4 bits, bit index 3 bits; all wrap only as defined above.
// TESTING  (TICK_DIV=4, so 1 bit = 64 clk)
//  1. Drive 8N1 frame 0xA5, iRX_READY=0 -> oRX_BYTE=0xA5, oRX_VALID=1 and held; iRX_READY=1 for 1 clk -> oRX_VALID=0 next clk.
//  2. Low glitch of 20 clk on idle line -> no oRX_VALID, no flags; oBUSY back to 0 within 64 clk.
//  3. Frame 0x3C with stop=0, then line low 300 clk, then high -> exactly one oFRAME_ERR pulse, no byte; next frame 0x55 received correctly.
//  4. Frames 0x11 then 0x22 back-to-back, iRX_READY=0 -> oRX_BYTE=0x11, one oOVERRUN pulse; then pop -> oRX_VALID=0.
//  5. Assert reset during data bit 3 of 0xFF -> all outputs 0 immediately; after release, frame 0x7E -> oRX_BYTE=0x7E, no flags.
//  6. Frame 0x00 with a 1-clk high spike at sample 8 of bit 2 -> majority rejects the spike, oRX_BYTE=0x00.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 8N1 UART receiver with a 16x oversample tick divider,
// a 2-flop input synchronizer and a 3-sample majority vote per bit.
// Received bytes are held in a valid/ready output register. Framing errors
// and overruns are reported as 1-cycle pulses.
`timescale 1ns/1ps

module uart_rx_oversample #(
    parameter int unsigned TICK_DIV = 27   // clk cycles per oversample tick, legal 2..255
) (
    input  logic       clk,
    input  logic       reset,        // asynchronous, active-low
    input  logic       iRX_DATA,
    input  logic       iRX_READY,
    output logic [7:0] oRX_BYTE,
    output logic       oRX_VALID,
    output logic       oFRAME_ERR,
    output logic       oOVERRUN,
    output logic       oBUSY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    logic       sync1_q, sync2_q;
    logic       rx_s;
    state_t     state_q;
    logic [7:0] tcnt_q, tcnt_d;
    logic [3:0] scnt_q, scnt_d;
    logic [2:0] bidx_q;
    logic       samp7_q, samp8_q;
    logic [7:0] shreg_q;
    logic [7:0] rx_byte_q;
    logic       rx_valid_q, frame_err_q, overrun_q, busy_q;

    logic       tick, eval_tick, end_tick, maj, pop;

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the synchronizer resets to the idle (high) level, otherwise
        // leaving reset would look like a start edge.
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep the two flops as a real
            // pipeline; blocking would collapse them into one stage.
            sync1_q <= iRX_DATA;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s      = sync2_q;
    assign tick      = (tcnt_q == TICK_LAST);
    assign eval_tick = tick && (scnt_q == 4'd9);
    assign end_tick  = tick && (scnt_q == 4'd15);
    // Third sample is the live synchronized line on the scnt==9 tick.
    assign maj       = (samp7_q & samp8_q) | (samp7_q & rx_s) | (samp8_q & rx_s);
    assign pop       = rx_valid_q & iRX_READY;

    // Oversample timebase: held at zero while idle so every frame is
    // phase-locked to its own start edge.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs (no latch).
        tcnt_d = tcnt_q;
        scnt_d = scnt_q;
        if (state_q == ST_IDLE) begin
            tcnt_d = '0;
            scnt_d = '0;
        end else if (tick) begin
            tcnt_d = '0;
            scnt_d = scnt_q + 4'd1;
        end else begin
            tcnt_d = tcnt_q + 8'd1;
        end
    end

    // Receive state machine with registered outputs and output handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            scnt_q      <= '0;
            bidx_q      <= '0;
            samp7_q     <= 1'b0;
            samp8_q     <= 1'b0;
            shreg_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            tcnt_q      <= tcnt_d;
            scnt_q      <= scnt_d;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            if (pop) rx_valid_q <= 1'b0;

            if (tick && scnt_q == 4'd7) samp7_q <= rx_s;
            if (tick && scnt_q == 4'd8) samp8_q <= rx_s;

            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (eval_tick && maj) begin
                        // Start bit did not hold low at mid-bit: false start.
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (end_tick) begin
                        state_q <= ST_DATA;
                        bidx_q  <= '0;
                    end
                end
                ST_DATA: begin
                    if (eval_tick) shreg_q <= {maj, shreg_q[7:1]};
                    if (end_tick) begin
                        if (bidx_q == 3'd7) state_q <= ST_STOP;
                        else                bidx_q  <= bidx_q + 3'd1;
                    end
                end
                ST_STOP: begin
                    if (eval_tick) begin
                        if (maj) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            if (!rx_valid_q || pop) begin
                                rx_byte_q  <= shreg_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oRX_BYTE   = rx_byte_q;
    assign oRX_VALID  = rx_valid_q;
    assign oFRAME_ERR = frame_err_q;
    assign oOVERRUN   = overrun_q;
    assign oBUSY      = busy_q;

endmodule
